// File: rtl/sram_access_ctrl_pkg.sv
// Shared definitions for the SRAM access controller: request sizes, FSM states,
// the latched request record and the request legality check.
package sram_access_ctrl_pkg;

  localparam logic [1:0]  REQ_SIZE_BYTE = 2'd0;
  localparam logic [1:0]  REQ_SIZE_HALF = 2'd1;
  localparam logic [1:0]  REQ_SIZE_WORD = 2'd2;
  localparam logic [1:0]  REQ_SIZE_RSVD = 2'd3;

  localparam logic        TRUE      = 1'b1;
  localparam logic        FALSE     = 1'b0;
  localparam logic [31:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  // Only the fields still needed after the SRAM-side outputs have been registered.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
  } req_t;

  function automatic logic req_error(input logic [1:0]  size,
                                     input logic [31:0] addr,
                                     input logic [32:0] limit);
    return (size == REQ_SIZE_RSVD) ||
           ((size == REQ_SIZE_HALF) && addr[0]) ||
           ((size == REQ_SIZE_WORD) && (addr[1:0] != 2'b00)) ||
           ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/sram_access_ctrl_lane_align.sv
// Combinational byte-lane steering: size/offset to lane enables, store data
// replication and big-endian load extraction with sign/zero extension.
module sram_lane_align
  import sram_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sgn,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  sel,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    // Byte offset k lives in lane 3-k; ~off is 3-off for a 2-bit offset.
    lane_byte = rdata_in[{~off, 3'b000} +: 8];
    lane_half = off[1] ? rdata_in[15:0] : rdata_in[31:16];
    sel       = '0;
    wdata_out = '0;
    rdata_out = '0;
    case (size)
      REQ_SIZE_BYTE: begin
        sel       = 4'b1000 >> off;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = {{24{sgn & lane_byte[7]}}, lane_byte};
      end
      REQ_SIZE_HALF: begin
        sel       = off[1] ? 4'b0011 : 4'b1100;
        wdata_out = {2{wdata_in[15:0]}};
        rdata_out = {{16{sgn & lane_half[15]}}, lane_half};
      end
      REQ_SIZE_WORD: begin
        sel       = 4'b1111;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
      end
      default: begin
        sel       = '0;
        wdata_out = '0;
        rdata_out = '0;
      end
    endcase
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Load/store initiator for a single-port word SRAM with a 1-cycle registered read.
// One transaction in flight; all SRAM-side and response outputs are registered.
module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        sram_ce,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [3:0]  sram_sel,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        sram_ce_q, sram_ce_d;
  logic        sram_we_q, sram_we_d;
  logic [31:0] sram_addr_q, sram_addr_d;
  logic [3:0]  sram_sel_q, sram_sel_d;
  logic [31:0] sram_wdata_q, sram_wdata_d;

  logic        is_idle;
  logic        bad_req;
  logic [1:0]  al_size, al_off;
  logic        al_sgn;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata, al_rdata;

  assign is_idle = (state_q == ST_IDLE);
  assign bad_req = req_error(req_size, req_addr, MEM_LIMIT);

  // In IDLE the aligner steers the incoming request (SRAM outputs are registered
  // at accept); afterwards it serves the latched request for load extraction.
  assign al_size = is_idle ? req_size      : req_q.size;
  assign al_off  = is_idle ? req_addr[1:0] : req_q.off;
  assign al_sgn  = is_idle ? req_signed    : req_q.sgn;

  sram_lane_align u_align (
    .size      (al_size),
    .off       (al_off),
    .sgn       (al_sgn),
    .wdata_in  (req_wdata),
    .rdata_in  (sram_rdata),
    .sel       (al_sel),
    .wdata_out (al_wdata),
    .rdata_out (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      rsp_valid_q  <= FALSE;
      rsp_err_q    <= FALSE;
      rsp_rdata_q  <= '0;
      sram_ce_q    <= FALSE;
      sram_we_q    <= FALSE;
      sram_addr_q  <= '0;
      sram_sel_q   <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      sram_ce_q    <= sram_ce_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_sel_q   <= sram_sel_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_valid) state_d = bad_req ? ST_RESP : ST_ACCESS;
      ST_ACCESS:  state_d = req_q.we ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d        = req_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    sram_ce_d    = FALSE;
    sram_we_d    = FALSE;
    sram_addr_d  = '0;
    sram_sel_d   = '0;
    sram_wdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = '{we: req_we, size: req_size, sgn: req_signed, off: req_addr[1:0]};
          if (bad_req) begin
            rsp_valid_d = TRUE;
            rsp_err_d   = TRUE;
            rsp_rdata_d = ZERO_WORD;
          end else begin
            sram_ce_d    = TRUE;
            sram_we_d    = req_we;
            sram_addr_d  = {req_addr[31:2], 2'b00};
            sram_sel_d   = al_sel;
            sram_wdata_d = al_wdata;
          end
        end
      end
      ST_ACCESS: begin
        if (req_q.we) begin
          rsp_valid_d = TRUE;
          rsp_err_d   = FALSE;
          rsp_rdata_d = ZERO_WORD;
        end
      end
      ST_CAPTURE: begin
        rsp_valid_d = TRUE;
        rsp_err_d   = FALSE;
        rsp_rdata_d = al_rdata;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = FALSE;
          rsp_err_d   = FALSE;
          rsp_rdata_d = ZERO_WORD;
        end
      end
      default: ;
    endcase
  end

  assign req_ready  = is_idle;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign sram_ce    = sram_ce_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_sel   = sram_sel_q;
  assign sram_wdata = sram_wdata_q;

endmodule
